// File: rtl/wam_pkg.sv
// -----------------------------------------------------------------------------
// wam_pkg
// Shared definitions for the whack-a-mole player-input block:
//   - NUM_HOLES   : number of hole buttons / mole positions
//   - wam_state_e : game state encoding (IDLE / PLAY / OVER)
//   - bcd_digit_inc / bcd_score_inc : BCD increment helpers for the score
// -----------------------------------------------------------------------------
package wam_pkg;

    localparam int NUM_HOLES = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } wam_state_e;

    // Increment one BCD digit; result is {carry, digit}. 9 wraps to 0 with carry.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] digit);
        logic [4:0] res;
        if (digit >= 4'd9) begin
            res = {1'b1, 4'd0};
        end else begin
            res = {1'b0, digit + 4'd1};
        end
        return res;
    endfunction

    // Increment a two-digit BCD score, holding at 99.
    function automatic logic [7:0] bcd_score_inc(input logic [7:0] score);
        logic [4:0] ones;
        logic [4:0] tens;
        logic [7:0] res;
        ones = bcd_digit_inc(score[3:0]);
        tens = bcd_digit_inc(score[7:4]);
        if (score == 8'h99) begin
            res = score;
        end else if (ones[4]) begin
            res = {tens[3:0], ones[3:0]};
        end else begin
            res = {score[7:4], ones[3:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/wam_deb.sv
// -----------------------------------------------------------------------------
// wam_deb
// One-bit button conditioner: two-flop synchronizer followed by a
// counter-based debouncer. The debounced level only follows the synchronized
// input after the mismatch has persisted for the full debounce window, so
// bounce pulses shorter than DB_CYCLES samples never reach db.
//
// Parameters:
//   DB_CYCLES : debounce window in clk_19 samples (2..7)
// Ports:
//   clk_19 in  1  game tick clock
//   clr_n  in  1  asynchronous active-low reset
//   btn    in  1  raw asynchronous button, 1 = pressed
//   db     out 1  debounced, synchronized button level
// -----------------------------------------------------------------------------
module wam_deb
    import wam_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk_19,
    input  logic clr_n,
    input  logic btn,
    output logic db
);

    // Counter value at which a still-differing sample is accepted. The
    // counter starts at 0 on the first differing sample, so db moves
    // DB_CYCLES+2 edges after the raw edge is first sampled.
    localparam logic [2:0] DB_TH_C = 3'(DB_CYCLES);

    logic       sync1_r;
    logic       sync2_r;
    logic       db_r;
    logic [2:0] cnt_r;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk_19 or negedge clr_n) begin
        if (!clr_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: count consecutive mismatches, accept the new level at threshold.
    always_ff @(posedge clk_19 or negedge clr_n) begin
        if (!clr_n) begin
            db_r  <= 1'b0;
            cnt_r <= 3'd0;
        end else begin
            if (sync2_r == db_r) begin
                cnt_r <= 3'd0;
            end else if (cnt_r == DB_TH_C) begin
                db_r  <= sync2_r;
                cnt_r <= 3'd0;
            end else begin
                cnt_r <= cnt_r + 3'd1;
            end
        end
    end

    assign db = db_r;

endmodule

// File: rtl/wam_hit.sv
// -----------------------------------------------------------------------------
// wam_hit
// Player-input side of the whack-a-mole game. Conditions the eight hole
// buttons, turns each debounced rising edge into a press, keeps only the
// lowest-index press per cycle, and judges it against the mole pattern.
// Runs the IDLE/PLAY/OVER game state, a saturating two-digit BCD score and
// a miss counter that ends the game at MISS_LIMIT.
//
// Parameters:
//   DB_CYCLES  : debounce window in clk_19 samples (2..7)
//   MISS_LIMIT : miss count that ends the game (1..15)
// Ports:
//   clk_19    in  1  game tick clock (shared with the mole generator)
//   clr_n     in  1  asynchronous active-low reset
//   btn       in  8  raw bouncing hole buttons, 1 = pressed
//   holes     in  8  current mole pattern, 1 = mole present
//   hit       out 8  one-cycle pulse on a successful whack (one-hot or 0)
//   score_bcd out 8  BCD score, tens in [7:4], holds at 99
//   miss_cnt  out 4  binary miss count
//   playing   out 1  high in PLAY
//   game_over out 1  high in OVER
// -----------------------------------------------------------------------------
module wam_hit
    import wam_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned MISS_LIMIT = 8
) (
    input  logic       clk_19,
    input  logic       clr_n,
    input  logic [7:0] btn,
    input  logic [7:0] holes,
    output logic [7:0] hit,
    output logic [7:0] score_bcd,
    output logic [3:0] miss_cnt,
    output logic       playing,
    output logic       game_over
);

    localparam logic [3:0] MISS_LIM_C = 4'(MISS_LIMIT);

    logic [NUM_HOLES-1:0] db_s;
    logic [NUM_HOLES-1:0] db_d_r;
    logic [NUM_HOLES-1:0] press_s;
    logic [NUM_HOLES-1:0] sel_s;
    logic                 accept_s;
    logic                 mole_s;

    wam_state_e           state_r;
    wam_state_e           state_nx_s;
    logic [7:0]           hit_r;
    logic [7:0]           hit_nx_s;
    logic [7:0]           score_r;
    logic [7:0]           score_nx_s;
    logic [3:0]           miss_r;
    logic [3:0]           miss_nx_s;
    logic [3:0]           miss_inc_s;

    for (genvar i = 0; i < NUM_HOLES; i++) begin : g_deb
        wam_deb #(
            .DB_CYCLES (DB_CYCLES)
        ) u_deb (
            .clk_19 (clk_19),
            .clr_n  (clr_n),
            .btn    (btn[i]),
            .db     (db_s[i])
        );
    end

    // Delayed debounced levels for rising-edge detection.
    always_ff @(posedge clk_19 or negedge clr_n) begin
        if (!clr_n) begin
            db_d_r <= '0;
        end else begin
            db_d_r <= db_s;
        end
    end

    // Rising edges only; x & -x isolates the lowest set bit, so any
    // simultaneous higher-index presses are dropped rather than queued.
    assign press_s  = db_s & ~db_d_r;
    assign sel_s    = press_s & (~press_s + 8'd1);
    assign accept_s = |press_s;
    assign mole_s   = |(sel_s & holes);

    // Next-state, hit, score and miss logic for the game FSM.
    always_comb begin
        state_nx_s = state_r;
        hit_nx_s   = 8'd0;
        score_nx_s = score_r;
        miss_nx_s  = miss_r;
        miss_inc_s = miss_r + 4'd1;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_PLAY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (accept_s) begin
                    if (mole_s) begin
                        hit_nx_s   = sel_s;
                        score_nx_s = bcd_score_inc(score_r);
                    end else begin
                        miss_nx_s = miss_inc_s;
                        if (miss_inc_s == MISS_LIM_C) begin
                            state_nx_s = ST_OVER;
                        end else begin
                            state_nx_s = ST_PLAY;
                        end
                    end
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            ST_OVER: begin
                state_nx_s = ST_OVER;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, hit pulse, score and miss registers.
    always_ff @(posedge clk_19 or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= ST_IDLE;
            hit_r   <= 8'd0;
            score_r <= 8'd0;
            miss_r  <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            hit_r   <= hit_nx_s;
            score_r <= score_nx_s;
            miss_r  <= miss_nx_s;
        end
    end

    assign hit       = hit_r;
    assign score_bcd = score_r;
    assign miss_cnt  = miss_r;
    assign playing   = (state_r == ST_PLAY);
    assign game_over = (state_r == ST_OVER);

endmodule

// File: tb/tb_wam_hit.sv
// -----------------------------------------------------------------------------
// tb_wam_hit
// Directed bench for wam_hit (DB_CYCLES=4, MISS_LIMIT=3). Outputs are
// packed as {hit, score_bcd, miss_cnt, playing, game_over} and compared
// against hand-computed values. Inputs change and outputs are sampled 1ns
// after the rising edge. "Edge k" below counts rising edges after the
// input change, the first of which is the first sample of the button.
// -----------------------------------------------------------------------------
module tb_wam_hit;

    logic       clk_19;
    logic       clr_n;
    logic [7:0] btn;
    logic [7:0] holes;
    logic [7:0] hit;
    logic [7:0] score_bcd;
    logic [3:0] miss_cnt;
    logic       playing;
    logic       game_over;

    int n_vec  = 0;
    int n_miss = 0;

    logic [21:0] snap_s;
    logic [21:0] p0;
    logic [21:0] p1;
    logic [21:0] p2;
    logic [7:0]  acc;

    wam_hit #(
        .DB_CYCLES  (4),
        .MISS_LIMIT (3)
    ) dut (
        .clk_19    (clk_19),
        .clr_n     (clr_n),
        .btn       (btn),
        .holes     (holes),
        .hit       (hit),
        .score_bcd (score_bcd),
        .miss_cnt  (miss_cnt),
        .playing   (playing),
        .game_over (game_over)
    );

    assign snap_s = {hit, score_bcd, miss_cnt, playing, game_over};

    initial begin
        clk_19 = 1'b0;
        forever #5 clk_19 = ~clk_19;
    end

    function automatic logic [21:0] ex(input logic [7:0] h, input logic [7:0] s,
                                       input logic [3:0] m, input logic p, input logic o);
        return {h, s, m, p, o};
    endfunction

    task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_19);
        #1;
    endtask

    // Clean press: snapshot after edge 7 (before judge), edge 8 (judge), edge 9.
    task automatic press(input int idx, output logic [21:0] pre,
                         output logic [21:0] at, output logic [21:0] post);
        btn[idx] = 1'b1;
        repeat (7) tick();
        pre = snap_s;
        tick();
        at = snap_s;
        tick();
        post = snap_s;
        btn[idx] = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        btn   = 8'd0;
        holes = 8'd0;
        clr_n = 1'b0;
        repeat (3) tick();
        chk("reset", snap_s, ex(8'h00, 8'h00, 4'd0, 1'b0, 1'b0));
        clr_n = 1'b1;

        // Start: press in IDLE only enters PLAY
        holes = 8'hFF;
        press(3, p0, p1, p2);
        chk("start_pre", p0, ex(8'h00, 8'h00, 4'd0, 1'b0, 1'b0));
        chk("start_at",  p1, ex(8'h00, 8'h00, 4'd0, 1'b1, 1'b0));

        // Hit on hole 5
        holes = 8'h20;
        press(5, p0, p1, p2);
        chk("hit_pre",  p0, ex(8'h00, 8'h00, 4'd0, 1'b1, 1'b0));
        chk("hit_at",   p1, ex(8'h20, 8'h01, 4'd0, 1'b1, 1'b0));
        chk("hit_post", p2, ex(8'h00, 8'h01, 4'd0, 1'b1, 1'b0));

        // Bounce on hole 2: 1-0-1-0 then hold
        holes = 8'h04;
        btn[2] = 1'b1; tick();
        btn[2] = 1'b0; tick();
        btn[2] = 1'b1; tick();
        btn[2] = 1'b0; tick();
        btn[2] = 1'b1;
        repeat (7) tick();
        chk("bounce_pre", snap_s, ex(8'h00, 8'h01, 4'd0, 1'b1, 1'b0));
        tick();
        chk("bounce_at", snap_s, ex(8'h04, 8'h02, 4'd0, 1'b1, 1'b0));
        acc = 8'h00;
        repeat (6) begin tick(); acc = acc | hit; end
        btn[2] = 1'b0;
        repeat (10) begin tick(); acc = acc | hit; end
        chk("bounce_once", {14'd0, acc}, 22'd0);

        // Priority: holes 1 and 6 together
        holes = 8'h42;
        btn[1] = 1'b1;
        btn[6] = 1'b1;
        repeat (7) tick();
        chk("prio_pre", snap_s, ex(8'h00, 8'h02, 4'd0, 1'b1, 1'b0));
        tick();
        chk("prio_at", snap_s, ex(8'h02, 8'h03, 4'd0, 1'b1, 1'b0));
        acc = 8'h00;
        repeat (4) begin tick(); acc = acc | hit; end
        btn[1] = 1'b0;
        btn[6] = 1'b0;
        repeat (10) begin tick(); acc = acc | hit; end
        chk("prio_no_6", {14'd0, acc}, 22'd0);
        chk("prio_score", snap_s, ex(8'h00, 8'h03, 4'd0, 1'b1, 1'b0));

        // Score 03 -> 09 -> 10 -> 99 -> saturate
        holes = 8'h01;
        repeat (6) press(0, p0, p1, p2);
        chk("score_09", snap_s, ex(8'h00, 8'h09, 4'd0, 1'b1, 1'b0));
        press(0, p0, p1, p2);
        chk("score_10", p1, ex(8'h01, 8'h10, 4'd0, 1'b1, 1'b0));
        repeat (89) press(0, p0, p1, p2);
        chk("score_99", snap_s, ex(8'h00, 8'h99, 4'd0, 1'b1, 1'b0));
        press(0, p0, p1, p2);
        chk("score_sat", p1, ex(8'h01, 8'h99, 4'd0, 1'b1, 1'b0));

        // Misses up to MISS_LIMIT=3
        holes = 8'h00;
        press(7, p0, p1, p2);
        chk("miss_1", p1, ex(8'h00, 8'h99, 4'd1, 1'b1, 1'b0));
        press(7, p0, p1, p2);
        chk("miss_2", p1, ex(8'h00, 8'h99, 4'd2, 1'b1, 1'b0));
        press(7, p0, p1, p2);
        chk("miss_3_pre", p0, ex(8'h00, 8'h99, 4'd2, 1'b1, 1'b0));
        chk("miss_3_at",  p1, ex(8'h00, 8'h99, 4'd3, 1'b0, 1'b1));
        holes = 8'h80;
        press(7, p0, p1, p2);
        chk("over_frozen", p1, ex(8'h00, 8'h99, 4'd3, 1'b0, 1'b1));

        // Reset mid-debounce, button held through reset
        btn[0] = 1'b1;
        repeat (3) tick();
        clr_n = 1'b0;
        #1;
        chk("async_clr", snap_s, ex(8'h00, 8'h00, 4'd0, 1'b0, 1'b0));
        repeat (2) tick();
        chk("clr_hold", snap_s, ex(8'h00, 8'h00, 4'd0, 1'b0, 1'b0));
        clr_n = 1'b1;
        repeat (7) tick();
        chk("held_pre", snap_s, ex(8'h00, 8'h00, 4'd0, 1'b0, 1'b0));
        tick();
        chk("held_at", snap_s, ex(8'h00, 8'h00, 4'd0, 1'b1, 1'b0));
        btn[0] = 1'b0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
